// File: rtl/pll_clock_monitor.sv
// PLL output checker in the refclk domain: synchronises lock and one PLL clock,
// measures its edge count per window and gates a downstream reset on stability.
module pll_clock_monitor #(
  parameter int WINDOW_CYCLES = 50000,
  parameter int EXP_COUNT     = 1536,
  parameter int TOL           = 4,
  parameter int GOOD_WINDOWS  = 4,
  parameter int CNT_W         = 16
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             locked_in,
  input  logic             mon_clk,
  input  logic             clear,
  output logic [CNT_W-1:0] freq_count,
  output logic             count_valid,
  output logic             in_range,
  output logic             stable,
  output logic             lost_lock,
  output logic             rst_out_n
);

  localparam int WIN_W  = $clog2(WINDOW_CYCLES + 1);
  localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);
  localparam int LO_BOUND = (EXP_COUNT > TOL) ? (EXP_COUNT - TOL) : 0;
  localparam int HI_BOUND = EXP_COUNT + TOL;
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(GOOD_WINDOWS);

  typedef enum logic [1:0] {IDLE = 2'd0, MEASURE = 2'd1, EVAL = 2'd2} state_t;

  // Widened unsigned compare; a saturated count is never in range.
  function automatic logic range_ok(input logic [CNT_W-1:0] cnt);
    logic [31:0] c32;
    c32 = 32'(cnt);
    return (cnt != CNT_MAX) && (c32 >= 32'(LO_BOUND)) && (c32 <= 32'(HI_BOUND));
  endfunction

  logic              lk_meta_r, lk_s_r;
  logic              mon_s1_r, mon_s2_r, mon_s3_r;
  logic              mon_rise_s, lock_loss_s;
  state_t            state_r, state_nx;
  logic [WIN_W-1:0]  win_cnt_r, win_nx;
  logic [CNT_W-1:0]  edge_cnt_r, edge_nx, edge_inc_s;
  logic [GOOD_W-1:0] good_cnt_r, good_nx;
  logic [CNT_W-1:0]  freq_count_r, freq_nx;
  logic              count_valid_r, valid_nx;
  logic              in_range_r, inr_nx;
  logic              stable_r, stable_nx;
  logic              lost_lock_r, lost_nx;
  logic              rst_out_n_r;

  assign mon_rise_s  = mon_s2_r & ~mon_s3_r;
  assign lock_loss_s = (state_r != IDLE) && !lk_s_r;
  assign edge_inc_s  = (edge_cnt_r == CNT_MAX) ? CNT_MAX : (edge_cnt_r + CNT_W'(1));

  // Next-state and next-value logic for the measurement FSM.
  always_comb begin
    state_nx  = state_r;
    win_nx    = win_cnt_r;
    edge_nx   = edge_cnt_r;
    good_nx   = good_cnt_r;
    freq_nx   = freq_count_r;
    valid_nx  = 1'b0;
    inr_nx    = in_range_r;
    stable_nx = stable_r;
    if (lock_loss_s) begin
      lost_nx = 1'b1;
    end else if (clear) begin
      lost_nx = 1'b0;
    end else begin
      lost_nx = lost_lock_r;
    end
    case (state_r)
      IDLE: begin
        win_nx    = {WIN_W{1'b0}};
        edge_nx   = {CNT_W{1'b0}};
        good_nx   = {GOOD_W{1'b0}};
        stable_nx = 1'b0;
        if (lk_s_r) begin
          state_nx = MEASURE;
        end else begin
          state_nx = IDLE;
        end
      end
      MEASURE: begin
        if (!lk_s_r) begin
          state_nx  = IDLE;
          win_nx    = {WIN_W{1'b0}};
          edge_nx   = {CNT_W{1'b0}};
          good_nx   = {GOOD_W{1'b0}};
          stable_nx = 1'b0;
        end else begin
          edge_nx = mon_rise_s ? edge_inc_s : edge_cnt_r;
          if (win_cnt_r == WIN_LAST) begin
            state_nx = EVAL;
            win_nx   = {WIN_W{1'b0}};
          end else begin
            state_nx = MEASURE;
            win_nx   = win_cnt_r + WIN_W'(1);
          end
        end
      end
      EVAL: begin
        if (!lk_s_r) begin
          state_nx  = IDLE;
          win_nx    = {WIN_W{1'b0}};
          edge_nx   = {CNT_W{1'b0}};
          good_nx   = {GOOD_W{1'b0}};
          stable_nx = 1'b0;
        end else begin
          state_nx = MEASURE;
          freq_nx  = edge_cnt_r;
          valid_nx = 1'b1;
          inr_nx   = range_ok(edge_cnt_r);
          if (inr_nx) begin
            good_nx = (good_cnt_r == GOOD_MAX) ? GOOD_MAX : (good_cnt_r + GOOD_W'(1));
          end else begin
            good_nx = {GOOD_W{1'b0}};
          end
          stable_nx = (good_nx == GOOD_MAX);
          win_nx    = {WIN_W{1'b0}};
          // An edge landing in the evaluation cycle opens the next window.
          edge_nx   = mon_rise_s ? CNT_W'(1) : {CNT_W{1'b0}};
        end
      end
      default: begin
        state_nx  = IDLE;
        win_nx    = {WIN_W{1'b0}};
        edge_nx   = {CNT_W{1'b0}};
        good_nx   = {GOOD_W{1'b0}};
        stable_nx = 1'b0;
      end
    endcase
  end

  // Synchronisers, FSM state and registered outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta_r     <= 1'b0;
      lk_s_r        <= 1'b0;
      mon_s1_r      <= 1'b0;
      mon_s2_r      <= 1'b0;
      mon_s3_r      <= 1'b0;
      state_r       <= IDLE;
      win_cnt_r     <= {WIN_W{1'b0}};
      edge_cnt_r    <= {CNT_W{1'b0}};
      good_cnt_r    <= {GOOD_W{1'b0}};
      freq_count_r  <= {CNT_W{1'b0}};
      count_valid_r <= 1'b0;
      in_range_r    <= 1'b0;
      stable_r      <= 1'b0;
      lost_lock_r   <= 1'b0;
      rst_out_n_r   <= 1'b0;
    end else begin
      lk_meta_r     <= locked_in;
      lk_s_r        <= lk_meta_r;
      mon_s1_r      <= mon_clk;
      mon_s2_r      <= mon_s1_r;
      mon_s3_r      <= mon_s2_r;
      state_r       <= state_nx;
      win_cnt_r     <= win_nx;
      edge_cnt_r    <= edge_nx;
      good_cnt_r    <= good_nx;
      freq_count_r  <= freq_nx;
      count_valid_r <= valid_nx;
      in_range_r    <= inr_nx;
      stable_r      <= stable_nx;
      lost_lock_r   <= lost_nx;
      rst_out_n_r   <= stable_nx;
    end
  end

  assign freq_count  = freq_count_r;
  assign count_valid = count_valid_r;
  assign in_range    = in_range_r;
  assign stable      = stable_r;
  assign lost_lock   = lost_lock_r;
  assign rst_out_n   = rst_out_n_r;

endmodule
